// File: rtl/lemming_bump_conditioner.sv
// Bump-sensor conditioner for the lemming walker: per-channel synchroniser and debounce,
// single-cycle rising-edge pulses, and a saturating event counter.

module lemming_bump_channel #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic areset_n,
    input  logic sense_raw,
    output logic stable,
    output logic bump,
    output logic commit_rise
);
    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          disagree;
    logic          at_last;

    assign disagree    = (s2 != stable);
    assign at_last     = (cnt == LAST);
    // A 0->1 commit is the only thing that pulses or counts; falling commits are silent.
    assign commit_rise = disagree && at_last && s2;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            bump   <= 1'b0;
        end else begin
            s1   <= sense_raw;
            s2   <= s1;
            bump <= commit_rise;
            if (!disagree) begin
                cnt <= '0;
            end else if (at_last) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module lemming_bump_conditioner #(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             sense_left_raw,
    input  logic             sense_right_raw,
    input  logic             clear_count,
    output logic             bump_left,
    output logic             bump_right,
    output logic             stable_left,
    output logic             stable_right,
    output logic [CNT_W-1:0] bump_count
);
    logic           rise_left;
    logic           rise_right;
    logic [1:0]     inc;
    logic [CNT_W:0] sum;

    lemming_bump_channel #(.DEBOUNCE(DEBOUNCE)) u_left (
        .clk         (clk),
        .areset_n    (areset_n),
        .sense_raw   (sense_left_raw),
        .stable      (stable_left),
        .bump        (bump_left),
        .commit_rise (rise_left)
    );

    lemming_bump_channel #(.DEBOUNCE(DEBOUNCE)) u_right (
        .clk         (clk),
        .areset_n    (areset_n),
        .sense_raw   (sense_right_raw),
        .stable      (stable_right),
        .bump        (bump_right),
        .commit_rise (rise_right)
    );

    // One extra bit catches overflow so the count pins at all-ones instead of wrapping.
    assign inc = {1'b0, rise_left} + {1'b0, rise_right};
    assign sum = {1'b0, bump_count} + (CNT_W + 1)'(inc);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            bump_count <= '0;
        end else if (clear_count) begin
            bump_count <= '0;
        end else if (sum[CNT_W]) begin
            bump_count <= '1;
        end else begin
            bump_count <= sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_lemming_bump_conditioner.sv
// Scoreboard bench for lemming_bump_conditioner (DEBOUNCE=4, CNT_W=2): stimulus pushes the
// expected pulse cycle/count, a negedge monitor pops and checks every pulse the DUT emits.

module tb_lemming_bump_conditioner;
    logic       clk;
    logic       areset_n;
    logic       sense_left_raw;
    logic       sense_right_raw;
    logic       clear_count;
    logic       bump_left;
    logic       bump_right;
    logic       stable_left;
    logic       stable_right;
    logic [1:0] bump_count;

    typedef struct {
        int         cyc;
        logic       l;
        logic       r;
        logic [1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   compared = 0;
    int   errors = 0;

    lemming_bump_conditioner #(.DEBOUNCE(4), .CNT_W(2)) dut (
        .clk             (clk),
        .areset_n        (areset_n),
        .sense_left_raw  (sense_left_raw),
        .sense_right_raw (sense_right_raw),
        .clear_count     (clear_count),
        .bump_left       (bump_left),
        .bump_right      (bump_right),
        .stable_left     (stable_left),
        .stable_right    (stable_right),
        .bump_count      (bump_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        compared++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input int c, input logic l, input logic r, input logic [1:0] n);
        exp_t e;
        e.cyc = c;
        e.l   = l;
        e.r   = r;
        e.cnt = n;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse the DUT presents must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bump_left || bump_right) begin
                compared++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got l=%0b r=%0b cnt=%0d at cycle %0d, required no pulse",
                             bump_left, bump_right, bump_count, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.l !== bump_left || e.r !== bump_right || e.cnt !== bump_count) begin
                        errors++;
                        $display("FAIL pulse: got cyc=%0d l=%0b r=%0b cnt=%0d, required cyc=%0d l=%0b r=%0b cnt=%0d",
                                 cyc, bump_left, bump_right, bump_count, e.cyc, e.l, e.r, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        int k;
        areset_n        = 1'b0;
        sense_left_raw  = 1'b1;
        sense_right_raw = 1'b1;
        clear_count     = 1'b0;

        // Reset held with both sensors high: everything quiet.
        tick(3);
        chk("rst_bump_left", 8'(bump_left), 8'd0);
        chk("rst_bump_right", 8'(bump_right), 8'd0);
        chk("rst_stable_left", 8'(stable_left), 8'd0);
        chk("rst_stable_right", 8'(stable_right), 8'd0);
        chk("rst_count", 8'(bump_count), 8'd0);

        k = cyc;
        areset_n = 1'b1;
        expect_pulse(k + 6, 1'b1, 1'b1, 2'd2);
        tick(5);
        chk("rel_stable_left_before", 8'(stable_left), 8'd0);
        tick(1);
        chk("rel_stable_left_at", 8'(stable_left), 8'd1);
        chk("rel_stable_right_at", 8'(stable_right), 8'd1);
        tick(10);
        chk("rel_count", 8'(bump_count), 8'd2);

        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clear_count", 8'(bump_count), 8'd0);
        sense_left_raw  = 1'b0;
        sense_right_raw = 1'b0;
        tick(10);
        chk("fall_stable_left", 8'(stable_left), 8'd0);
        chk("fall_count", 8'(bump_count), 8'd0);

        // Clean left press and release.
        k = cyc;
        sense_left_raw = 1'b1;
        expect_pulse(k + 6, 1'b1, 1'b0, 2'd1);
        tick(5);
        chk("press_stable_before", 8'(stable_left), 8'd0);
        tick(1);
        chk("press_stable_at", 8'(stable_left), 8'd1);
        tick(14);
        chk("press_stable_held", 8'(stable_left), 8'd1);
        chk("press_count", 8'(bump_count), 8'd1);
        sense_left_raw = 1'b0;
        tick(5);
        chk("release_stable_before", 8'(stable_left), 8'd1);
        tick(1);
        chk("release_stable_at", 8'(stable_left), 8'd0);
        tick(4);

        // Right glitch of three highs alone: no commit.
        sense_right_raw = 1'b1;
        tick(3);
        sense_right_raw = 1'b0;
        tick(10);
        chk("glitch3_stable_right", 8'(stable_right), 8'd0);

        // Bounce 1,1,1,0,1,1,1,1 then held: pulse only after the final run of four.
        k = cyc;
        for (int i = 0; i < 8; i++) begin
            sense_right_raw = (i == 3) ? 1'b0 : 1'b1;
            tick(1);
        end
        expect_pulse(k + 10, 1'b0, 1'b1, 2'd2);
        tick(1);
        chk("bounce_stable_before", 8'(stable_right), 8'd0);
        tick(1);
        chk("bounce_stable_at", 8'(stable_right), 8'd1);
        sense_right_raw = 1'b0;
        tick(10);

        // Simultaneous rise: both pulses together, count +2.
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        k = cyc;
        sense_left_raw  = 1'b1;
        sense_right_raw = 1'b1;
        expect_pulse(k + 6, 1'b1, 1'b1, 2'd2);
        tick(10);
        chk("simul_count", 8'(bump_count), 8'd2);
        sense_left_raw  = 1'b0;
        sense_right_raw = 1'b0;
        tick(10);

        // Saturation at 3 with a 2-bit counter.
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        for (int p = 0; p < 5; p++) begin
            k = cyc;
            sense_left_raw = 1'b1;
            expect_pulse(k + 6, 1'b1, 1'b0, (p < 3) ? 2'(p + 1) : 2'd3);
            tick(8);
            sense_left_raw = 1'b0;
            tick(8);
        end
        chk("sat_count", 8'(bump_count), 8'd3);

        // Clear on the pulse edge wins over the increment; pulse still emitted.
        k = cyc;
        sense_left_raw = 1'b1;
        expect_pulse(k + 6, 1'b1, 1'b0, 2'd0);
        tick(5);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clear_on_pulse_count", 8'(bump_count), 8'd0);
        tick(4);
        sense_left_raw = 1'b0;
        tick(10);

        // Reset three edges into a left press: aborted count, fresh debounce after release.
        k = cyc;
        sense_left_raw = 1'b1;
        tick(3);
        areset_n = 1'b0;
        #1;
        chk("midrst_bump_left", 8'(bump_left), 8'd0);
        chk("midrst_count", 8'(bump_count), 8'd0);
        tick(1);
        areset_n = 1'b1;
        expect_pulse(k + 10, 1'b1, 1'b0, 2'd1);
        tick(12);
        chk("midrst_stable_left", 8'(stable_left), 8'd1);
        sense_left_raw = 1'b0;
        tick(10);

        chk("pending_pulses", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end
endmodule
